// File: rtl/bcd_to_bin_pkg.sv
// Shared types and constants for the reverse double-dabble BCD-to-binary converter.
package bcd_to_bin_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int         BCD_DIGIT_W    = 4;
   localparam logic [3:0] BCD_ADJ        = 4'd3;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;

endpackage

// File: rtl/bcd_to_bin_if.sv
// Request/result bundle between the BCD source and the converter.
interface bcd_to_bin_if
   import bcd_to_bin_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int BIN_W    = 14
);
   logic                            start_i;
   logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd_i;
   logic                            busy_o;
   logic                            done_o;
   logic [BIN_W-1:0]                num_o;
   logic                            err_o;

   modport slave  (input  start_i, bcd_i, output busy_o, done_o, num_o, err_o);
   modport master (output start_i, bcd_i, input  busy_o, done_o, num_o, err_o);
endinterface

// File: rtl/bcd_to_bin_digit_adj.sv
// One-digit correction step of reverse double-dabble: subtract 3 from digits of 8 or more.
module bcd_digit_adj
   import bcd_to_bin_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] digit_o
);

   assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i - BCD_ADJ) : digit_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter: one shift/adjust iteration per clock, BIN_W iterations.
//
//   state | meaning
//   IDLE  | waiting for start_i; latches bcd_i and validates digits
//   SHIFT | one shift-right / subtract-3 iteration per cycle (busy_o)
//   DONE  | one-cycle done_o; num_o/err_o already updated
module bcd_to_bin
   import bcd_to_bin_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int BIN_W    = 14
)(
   input  logic         clk_i,
   input  logic         rst_i,
   bcd_to_bin_if.slave  bus
);

   localparam int BCD_W = BCD_DIGIT_W * N_DIGITS;
   localparam int CNT_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_e             state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_shift, bcd_adj;
   logic [BIN_W-1:0]   bin_q, bin_d, bin_shift;
   logic [BIN_W-1:0]   num_q, num_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               bcd_bad;

   assign bcd_shift = bcd_q >> 1;
   assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      bcd_bad = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (bus.bcd_i[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) bcd_bad = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               bcd_d = bus.bcd_i;
               bin_d = '0;
               cnt_d = '0;
               if (bcd_bad) begin
                  num_d   = '0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            bcd_d = bcd_adj;
            bin_d = bin_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               num_d   = bin_shift;
               err_d   = 1'b0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
         num_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         err_q   <= err_d;
      end
   end

   assign bus.busy_o = (state_q == SHIFT);
   assign bus.done_o = (state_q == DONE);
   assign bus.num_o  = num_q;
   assign bus.err_o  = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized self-checking bench for bcd_to_bin against a decimal-arithmetic reference.
module tb_bcd_to_bin;

   localparam int N_DIGITS = 4;
   localparam int BIN_W    = 14;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   last_done = 0;
   int   prev_num  = 0;
   bit   prev_err  = 1'b0;

   bcd_to_bin_if #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) bus ();

   bcd_to_bin #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic void model(input logic [15:0] b, output int v, output bit e);
      int d;
      v = 0;
      e = 1'b0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         d = int'(b[i*4 +: 4]);
         if (d > 9) e = 1'b1;
         v = v * 10 + d;
      end
      if (e) v = 0;
   endfunction

   // Called just after a negedge while the DUT is in IDLE; returns at the negedge after done_o.
   task automatic conv(input logic [15:0] b);
      int lat, nbusy, exp_val;
      bit exp_err, seen, hold_ok, excl_ok;
      model(b, exp_val, exp_err);
      bus.bcd_i   = b;
      bus.start_i = 1'b1;
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      lat = 0; nbusy = 0; seen = 1'b0; hold_ok = 1'b1; excl_ok = 1'b1;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.busy_o) nbusy++;
         if (bus.busy_o && bus.done_o) excl_ok = 1'b0;
         if (bus.done_o) seen = 1'b1;
         else if (bus.num_o !== BIN_W'(prev_num) || bus.err_o !== prev_err) hold_ok = 1'b0;
      end
      check("done_seen", 32'(seen), 32'd1);
      check("latency",   32'(lat),  exp_err ? 32'd1 : 32'(BIN_W + 1));
      check("busy_cyc",  32'(nbusy), exp_err ? 32'd0 : 32'(BIN_W));
      check("num",       32'(bus.num_o), 32'(exp_val));
      check("err",       32'(bus.err_o), 32'(exp_err));
      check("hold",      32'(hold_ok), 32'd1);
      check("busy_done_excl", 32'(excl_ok), 32'd1);
      last_done = cyc;
      @(negedge clk);
      check("done_pulse_w", 32'(bus.done_o), 32'd0);
      prev_num = exp_val;
      prev_err = exp_err;
   endtask

   initial begin
      int t0, lat;
      bit seen;
      logic [15:0] b;

      rst = 1'b1;
      bus.start_i = 1'b0;
      bus.bcd_i   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_done", 32'(bus.done_o), 32'd0);
      check("rst_num",  32'(bus.num_o),  32'd0);
      check("rst_err",  32'(bus.err_o),  32'd0);
      rst = 1'b0;
      @(negedge clk);

      conv(16'h9999);
      check("t1_num_9999", 32'(bus.num_o), 32'd9999);

      conv(16'h0000);
      t0 = last_done;
      conv(16'h8191);
      check("t2_gap1", 32'(last_done - t0), 32'(BIN_W + 2));
      t0 = last_done;
      conv(16'h0001);
      check("t2_gap2", 32'(last_done - t0), 32'(BIN_W + 2));

      conv(16'h12A4);
      conv(16'h0042);

      // start held high through SHIFT with bcd_i changing underneath
      bus.bcd_i   = 16'h5000;
      bus.start_i = 1'b1;
      @(posedge clk);
      #1 bus.bcd_i = 16'h1111;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.done_o) seen = 1'b1;
      end
      check("t4_latency", 32'(lat), 32'(BIN_W + 1));
      check("t4_num", 32'(bus.num_o), 32'd5000);
      @(negedge clk);
      check("t4_done_w", 32'(bus.done_o), 32'd0);
      check("t4_idle_busy", 32'(bus.busy_o), 32'd0);
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      @(negedge clk);
      check("t4_restart", 32'(bus.busy_o), 32'd1);
      lat = 0; seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.done_o) seen = 1'b1;
      end
      check("t4_second_done", 32'(seen), 32'd1);
      check("t4_second_num", 32'(bus.num_o), 32'd1111);
      @(negedge clk);

      // asynchronous reset mid-conversion
      bus.bcd_i   = 16'h7777;
      bus.start_i = 1'b1;
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      repeat (6) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("t5_busy", 32'(bus.busy_o), 32'd0);
      check("t5_done", 32'(bus.done_o), 32'd0);
      check("t5_num",  32'(bus.num_o),  32'd0);
      check("t5_err",  32'(bus.err_o),  32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done_o) seen = 1'b1;
      end
      check("t5_no_done", 32'(seen), 32'd0);
      prev_num = 0;
      prev_err = 1'b0;
      conv(16'h0010);
      check("t5_num_10", 32'(bus.num_o), 32'd10);

      conv(16'h9990);
      conv(16'hA000);
      conv(16'h000F);
      conv(16'h0009);
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            if ($urandom_range(0, 19) == 0) b[i*4 +: 4] = 4'($urandom_range(10, 15));
            else                            b[i*4 +: 4] = 4'($urandom_range(0, 9));
         end
         conv(b);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
